// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU engine.
// Borrows the shared ALU for one ADD (multiply) or SUB (divide) per cycle while in RUN.
// Multiply uses shift-add; divide uses restoring division. Results land in HI/LO.
module muldiv_sequencer #(
    parameter int         WIDTH  = 32,
    parameter logic [3:0] OP_ADD = 4'b0000,
    parameter logic [3:0] OP_SUB = 4'b0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic [4:0]       alu_shamt,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_reg;
    logic             op_reg;        // 0 = MULTU, 1 = DIVU
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] opnd_reg;      // multiplicand for MULTU, divisor for DIVU
    logic [CW-1:0]    count_reg;
    logic             done_reg;
    logic             dz_reg;

    logic [WIDTH-1:0] sh;
    logic             msb;
    logic             carry;
    logic             div_take;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    // Divide works on the remainder shifted left by one with the next dividend bit;
    // the bit shifted out of HI forces a subtract since the true value exceeds 2^32.
    assign sh       = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
    assign msb      = hi_reg[WIDTH-1];
    assign carry    = (alu_result < hi_reg);
    assign div_take = msb | (sh >= opnd_reg);

    // ALU operand drive: only meaningful in RUN, parked at 0 + 0 otherwise.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = OP_ADD;
        if (state_reg == S_RUN) begin
            alu_a    = op_reg ? sh : hi_reg;
            alu_b    = opnd_reg;
            alu_ctrl = op_reg ? OP_SUB : OP_ADD;
        end
    end

    // One iteration of shift-add or restoring division using the ALU result.
    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        if (!op_reg) begin
            if (lo_reg[0]) begin
                hi_next = {carry, alu_result[WIDTH-1:1]};
                lo_next = {alu_result[0], lo_reg[WIDTH-1:1]};
            end else begin
                hi_next = {1'b0, hi_reg[WIDTH-1:1]};
                lo_next = {hi_reg[0], lo_reg[WIDTH-1:1]};
            end
        end else begin
            if (div_take) begin
                hi_next = alu_result;
                lo_next = {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = sh;
                lo_next = {lo_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sequencer FSM: accepts an op in IDLE, iterates WIDTH times in RUN, pulses done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            op_reg    <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            opnd_reg  <= '0;
            count_reg <= '0;
            done_reg  <= 1'b0;
            dz_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg    <= op;
                        count_reg <= '0;
                        dz_reg    <= 1'b0;
                        if (op && (src_b == '0)) begin
                            // Divide by zero finishes immediately without touching the ALU.
                            hi_reg    <= src_a;
                            lo_reg    <= '1;
                            opnd_reg  <= src_b;
                            dz_reg    <= 1'b1;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            hi_reg    <= '0;
                            lo_reg    <= op ? src_a : src_b;
                            opnd_reg  <= op ? src_b : src_a;
                            state_reg <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    hi_reg <= hi_next;
                    lo_reg <= lo_next;
                    if (count_reg == LAST) begin
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_reg != S_IDLE);
    assign alu_own   = (state_reg == S_RUN);
    assign done      = done_reg;
    assign dz        = dz_reg;
    assign hi        = hi_reg;
    assign lo        = lo_reg;
    assign alu_shamt = '0;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer; models the shared ALU
// and compares HI/LO/dz and handshake timing against plain 64-bit arithmetic.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        alu_own;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // External shared ALU: ADD for 0000, SUB for 0001.
    assign alu_result = (alu_ctrl == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

    muldiv_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .busy       (busy),
        .done       (done),
        .dz         (dz),
        .hi         (hi),
        .lo         (lo),
        .alu_own    (alu_own),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_shamt  (alu_shamt),
        .alu_result (alu_result)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Run one operation from IDLE and check result, timing and ALU usage.
    // If disturb is set, a second start with other operands is pulsed mid-run.
    task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb);
        logic [63:0] prod;
        logic [31:0] exp_hi, exp_lo;
        logic        exp_dz;
        int          exp_cyc, k, busy_cnt, own_cnt;
        bit          seen;
        if (o == 1'b0) begin
            prod   = {32'd0, a} * {32'd0, b};
            exp_hi = prod[63:32];
            exp_lo = prod[31:0];
            exp_dz = 1'b0;
        end else if (b == 32'd0) begin
            exp_hi = a;
            exp_lo = 32'hFFFF_FFFF;
            exp_dz = 1'b1;
        end else begin
            exp_hi = a % b;
            exp_lo = a / b;
            exp_dz = 1'b0;
        end
        exp_cyc = exp_dz ? 1 : 33;

        @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_cnt = 0; own_cnt = 0; seen = 1'b0; k = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (disturb && i == 5) begin
                start = 1'b1; op = ~o; src_a = $urandom; src_b = $urandom;
            end
            if (disturb && i == 7) start = 1'b0;
            if (busy) busy_cnt++;
            if (alu_own) begin
                own_cnt++;
                chk("alu_ctrl_run", {60'd0, alu_ctrl}, {63'd0, o});
            end
            if (done) begin
                seen = 1'b1; k = i;
                break;
            end
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        chk("done_cycle", k, exp_cyc);
        chk("busy_cycles", busy_cnt, exp_cyc);
        chk("own_cycles", own_cnt, exp_dz ? 0 : 32);
        chk("hi", {32'd0, hi}, {32'd0, exp_hi});
        chk("lo", {32'd0, lo}, {32'd0, exp_lo});
        chk("dz", {63'd0, dz}, {63'd0, exp_dz});
        chk("alu_idle", {alu_a, alu_b}, 64'd0);
        @(negedge clk);
        chk("done_pulse", {62'd0, done, busy}, 64'd0);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d cyc=%0d", o, a, b, hi, lo, dz, k);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {busy, done, dz, alu_own, alu_ctrl, alu_shamt}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        do_op(1'b0, 32'd7, 32'd6, 1'b0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(1'b1, 32'd100, 32'd7, 1'b0);
        do_op(1'b1, 32'h8000_0000, 32'd3, 1'b0);
        do_op(1'b1, 32'd5, 32'd0, 1'b0);

        // Results and dz hold in IDLE.
        repeat (4) @(negedge clk);
        chk("hold_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        chk("hold_dz", {63'd0, dz}, 64'd1);

        // Start during RUN is ignored; next start in IDLE is accepted.
        do_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        do_op(1'b1, 32'hDEAD_BEEF, 32'd1000, 1'b1);
        do_op(1'b1, 32'd9, 32'd4, 1'b0);

        // Reset mid-run aborts the op with no done pulse.
        @(negedge clk);
        op = 1'b0; src_a = 32'hABCD; src_b = 32'h1357; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outs", {busy, done, dz, alu_own, alu_ctrl, alu_shamt}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_alu", {alu_a, alu_b}, 64'd0);
        reset = 1'b0;
        begin
            bit any_done;
            any_done = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (done || busy) any_done = 1'b1;
            end
            chk("abort_quiet", {63'd0, any_done}, 64'd0);
        end

        // Randomized mix, biased towards small and zero divisors.
        for (int n = 0; n < 40; n++) begin
            logic        o;
            logic [31:0] a, b;
            o = 1'($urandom_range(0, 1));
            a = (($urandom_range(0, 3)) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            do_op(o, a, b, ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
